// File: rtl/matvec_engine.sv
// Matrix-vector multiply C = A x B: per-row show-ahead FIFOs, a B FIFO and a skewed MAC chain.
// Optional MATVEC_SIGNED_EN selects two's-complement operands (default: unsigned).
module matvec_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [$clog2(ROWS+1)-1:0]     wr_sel,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_ready,
    input  logic                          start,
    output logic                          ready,
    output logic                          busy,
    output logic                          done,
    output logic [ROWS*ACC_WIDTH-1:0]     c_out,
    output logic                          c_valid
);
    localparam int SW  = $clog2(ROWS + 1);
    localparam int PW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW  = $clog2(COLS + 1);
    localparam int RCW = $clog2(COLS + ROWS - 1);
    localparam logic [SW-1:0]  SEL_B    = SW'(ROWS);
    localparam logic [CW-1:0]  FULL     = CW'(COLS);
    localparam logic [PW-1:0]  PTR_LAST = PW'(COLS - 1);
    localparam logic [RCW-1:0] RUN_LAST = RCW'(COLS + ROWS - 2);
    localparam logic [RCW-1:0] RUN_COLS = RCW'(COLS);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                  state;
    logic [RCW-1:0]          run_cnt;
    logic [DATA_WIDTH-1:0]   mem    [0:ROWS][0:COLS-1];
    logic [PW-1:0]           wr_ptr [0:ROWS];
    logic [PW-1:0]           rd_ptr [0:ROWS];
    logic [CW-1:0]           count  [0:ROWS];
    logic [CW-1:0]           sel_count;
    logic                    push;
    logic                    start_ok;
    logic                    en0;
    logic                    en_pipe [1:ROWS-1];
    logic [DATA_WIDTH-1:0]   b_head;
    logic [DATA_WIDTH-1:0]   b_pipe  [1:ROWS-1];
    logic [ROWS:0]           pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Product widened to the accumulator; sign- or zero-extended depending on the build.
    function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
`ifdef MATVEC_SIGNED_EN
        logic signed [2*DATA_WIDTH-1:0] p;
        p = $signed(a) * $signed(b);
        return ACC_WIDTH'(p);
`else
        logic [2*DATA_WIDTH-1:0] p;
        p = a * b;
        return ACC_WIDTH'(p);
`endif
    endfunction

    // Write-side handshake and global ready.
    always_comb begin
        sel_count = '0;
        if (wr_sel <= SEL_B) sel_count = count[wr_sel];
        else                 sel_count = '0;
        wr_ready = !rst && (state == IDLE) && (wr_sel <= SEL_B) && (sel_count < FULL);
        push     = wr_valid && wr_ready;
        ready    = (state == IDLE);
        for (int f = 0; f <= ROWS; f++) begin
            if (count[f] != FULL) ready = 1'b0;
            else                  ready = ready;
        end
        start_ok = start && ready;
        en0      = (state == RUN) && (run_cnt < RUN_COLS);
        b_head   = mem[ROWS][rd_ptr[ROWS]];
    end

    // FIFO storage; contents need no reset because counts gate every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_sel][wr_ptr[wr_sel]] <= wr_data;
    end

    // FIFO pointers and occupancy; pushes happen only in IDLE, pops only in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f <= ROWS; f++) begin
                wr_ptr[f] <= '0;
                rd_ptr[f] <= '0;
                count[f]  <= '0;
            end
        end else begin
            for (int f = 0; f <= ROWS; f++) begin
                if (push && (wr_sel == SW'(f))) begin
                    wr_ptr[f] <= next_ptr(wr_ptr[f]);
                    count[f]  <= count[f] + CW'(1);
                end else if (pop[f]) begin
                    rd_ptr[f] <= next_ptr(rd_ptr[f]);
                    count[f]  <= count[f] - CW'(1);
                end
            end
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            c_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_ok) begin
                        state   <= RUN;
                        run_cnt <= '0;
                        busy    <= 1'b1;
                        c_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        c_valid <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + RCW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    c_valid <= 1'b0;
                end
            endcase
        end
    end

    // Skew pipes: row r sees the enable and B element of row r-1 one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < ROWS; r++) begin
                en_pipe[r] <= 1'b0;
                b_pipe[r]  <= '0;
            end
        end else begin
            for (int r = ROWS - 1; r > 1; r--) begin
                en_pipe[r] <= en_pipe[r-1];
                b_pipe[r]  <= b_pipe[r-1];
            end
            en_pipe[1] <= en0;
            b_pipe[1]  <= b_head;
        end
    end

    assign pop[ROWS] = en0;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic                  row_en;
        logic [DATA_WIDTH-1:0] row_b;
        logic [ACC_WIDTH-1:0]  acc;

        if (r == 0) begin : g_first
            assign row_en = en0;
            assign row_b  = b_head;
        end else begin : g_rest
            assign row_en = en_pipe[r];
            assign row_b  = b_pipe[r];
        end

        assign pop[r] = row_en;
        assign c_out[r*ACC_WIDTH +: ACC_WIDTH] = acc;

        // MAC cell: cleared on an accepted start, wraps modulo 2^ACC_WIDTH.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)           acc <= '0;
            else if (start_ok) acc <= '0;
            else if (row_en)   acc <= acc + mac_term(mem[r][rd_ptr[r]], row_b);
        end
    end
endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine: scoreboard of dot-product results checked at each done pulse.
module tb_matvec_engine;
    localparam int DW = 8;
    localparam int R  = 8;
    localparam int C  = 8;
    localparam int AW = 24;
    localparam int W  = R * AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [3:0]    wr_sel = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          start = 1'b0;
    logic          ready, busy, done, c_valid;
    logic [W-1:0]  c_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] a_m [R][C];
    logic [DW-1:0] b_v [C];
    logic [W-1:0]  sb [$];

    matvec_engine #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data),
        .wr_ready(wr_ready), .start(start), .ready(ready), .busy(busy), .done(done),
        .c_out(c_out), .c_valid(c_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference dot product from the stored A matrix and B vector.
    function automatic logic [W-1:0] model();
        logic [W-1:0] res;
        longint acc, pa, pb;
        res = '0;
        for (int r = 0; r < R; r++) begin
            acc = 0;
            for (int c = 0; c < C; c++) begin
`ifdef MATVEC_SIGNED_EN
                pa = longint'($signed(a_m[r][c]));
                pb = longint'($signed(b_v[c]));
`else
                pa = longint'(a_m[r][c]);
                pb = longint'(b_v[c]);
`endif
                acc = acc + pa * pb;
            end
            res[r*AW +: AW] = acc[AW-1:0];
        end
        return res;
    endfunction

    task automatic write_elem(input int sel, input logic [DW-1:0] d, input logic exp_rdy);
        wr_valid = 1'b1;
        wr_sel   = 4'(sel);
        wr_data  = d;
        #1;
        chk($sformatf("wr_ready_sel%0d", sel), W'(wr_ready), W'(exp_rdy));
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic load(input int nb);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) write_elem(r, a_m[r][c], 1'b1);
        for (int c = 0; c < nb; c++) write_elem(R, b_v[c], 1'b1);
    endtask

    task automatic run_check(input string tag);
        int lat, bcnt;
        chk({tag, "_ready"}, W'(ready), W'(1));
        sb.push_back(model());
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, W'(lat), W'(C + R));
        chk({tag, "_busy_cycles"}, W'(bcnt), W'(C + R - 1));
        chk({tag, "_c_valid"}, W'(c_valid), W'(1));
        if (sb.size() > 0) chk({tag, "_c_out"}, c_out, sb.pop_front());
        @(negedge clk);
        chk({tag, "_done_pulse"}, W'(done), W'(0));
        chk({tag, "_c_valid_hold"}, W'(c_valid), W'(1));
    endtask

    initial begin
        int ndone;
        logic [AW-1:0] word0;
        // Reset state
        @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_c_valid", W'(c_valid), W'(0));
        chk("rst_ready", W'(ready), W'(0));
        chk("rst_wr_ready", W'(wr_ready), W'(0));
        chk("rst_c_out", c_out, W'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: all ones
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a_m[r][c] = 8'd1;
        for (int c = 0; c < C; c++) b_v[c] = 8'd1;
        load(C);
        run_check("ones");
        chk("ones_word7", W'(c_out[7*AW +: AW]), W'(8));

        // 2: identity with two B vectors, no reset between
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a_m[r][c] = (r == c) ? 8'd1 : 8'd0;
        for (int c = 0; c < C; c++) b_v[c] = 8'(c + 1);
        load(C);
        chk("hold_c_valid_load", W'(c_valid), W'(1));
        run_check("ident_up");
        chk("ident_up_word3", W'(c_out[3*AW +: AW]), W'(4));
        for (int c = 0; c < C; c++) b_v[c] = 8'(C - c);
        load(C);
        run_check("ident_down");
        chk("ident_down_word0", W'(c_out[0 +: AW]), W'(8));

        // 3: maximum operands
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a_m[r][c] = 8'hFF;
        for (int c = 0; c < C; c++) b_v[c] = 8'hFF;
        load(C);
        run_check("max");
`ifndef MATVEC_SIGNED_EN
        chk("max_word5", W'(c_out[5*AW +: AW]), W'(24'h07F008));
`endif

        // 4: start while not ready, full FIFO and out-of-range writes
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a_m[r][c] = 8'(r + c);
        for (int c = 0; c < C; c++) b_v[c] = 8'(3 * c + 1);
        load(C - 1);
        chk("partial_ready", W'(ready), W'(0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", W'(busy), W'(0));
        chk("ignored_start_c_valid", W'(c_valid), W'(1));
        write_elem(R, b_v[C-1], 1'b1);
        write_elem(R, 8'd99, 1'b0);
        write_elem(9, 8'd5, 1'b0);
        run_check("drop");

        // 5: reset in the middle of RUN
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a_m[r][c] = (r == c) ? 8'd1 : 8'd0;
        for (int c = 0; c < C; c++) b_v[c] = 8'(c + 1);
        load(C);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_c_valid", W'(c_valid), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_c_out", c_out, W'(0));
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", W'(ndone), W'(0));
        chk("abort_ready", W'(ready), W'(0));
        for (int s = 0; s <= R; s++) begin
            wr_sel = 4'(s);
            #1;
            chk($sformatf("abort_empty_sel%0d", s), W'(wr_ready), W'(1));
        end
        @(negedge clk);

        // 6: sign handling
        for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) a_m[r][c] = 8'hFF;
        for (int c = 0; c < C; c++) b_v[c] = 8'h02;
        load(C);
        run_check("sign");
        word0 = c_out[0 +: AW];
`ifdef MATVEC_SIGNED_EN
        chk("sign_word0", W'(word0), W'(24'hFFFFF0));
`else
        chk("sign_word0", W'(word0), W'(24'h000FF0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/matvec_engine.md
Name: matvec_engine

Overview:
Parametrised matrix-vector multiply unit, C = A x B, with A of size ROWS x COLS and B of length COLS. It holds one show-ahead FIFO per A row and one for B, plus a skewed (systolic) chain of ROWS MAC cells. A control FSM sequences load, run and completion. It is the generalised successor of the fixed 8x8 MAC/FIFO array and is intended to sit behind a host/DMA write port.

Parameters:
DATA_WIDTH, 8, operand width of A and B elements
ROWS, 8, number of A rows, i.e. MAC cells and result words
COLS, 8, A columns = B length = depth of every FIFO
ACC_WIDTH, 24, accumulator/result width; must be >= 2*DATA_WIDTH+$clog2(COLS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wr_valid  in  1  host write strobe
wr_sel  in  $clog2(ROWS+1)  target FIFO: 0..ROWS-1 = A row r, ROWS = B
wr_data  in  DATA_WIDTH  element written (A row in column order, B in index order)
wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
start  in  1  single-cycle compute request
ready  out  1  IDLE and every FIFO holds exactly COLS entries
busy  out  1  FSM in RUN
done  out  1  one-cycle pulse on completion
c_out  out  ROWS*ACC_WIDTH  results; word r at bits [r*ACC_WIDTH +: ACC_WIDTH]
c_valid  out  1  c_out holds a completed result

Behaviour:
- Reset (async, active-high): FSM to IDLE; all FIFOs flushed to 0 entries; accumulators, B skew pipe and enable pipe cleared; wr_ready, ready, busy, done, c_valid = 0; c_out = 0. Reset mid-RUN aborts the operation with no done pulse.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE -> RUN: on start && ready. start while not ready, or outside IDLE, is ignored with no side effect.
- On entry to RUN: accumulators cleared and c_valid dropped.
- RUN lasts exactly COLS+ROWS-1 cycles, counted by a run counter, then the FSM goes to DONE.
- DONE lasts one cycle: done=1, c_valid=1, then IDLE. c_valid and c_out hold until the next accepted start.
- Latency: start accepted at cycle 0 gives RUN at cycles 1..COLS+ROWS-1 and done at cycle COLS+ROWS (16 for 8x8).
- wr_ready = (state==IDLE) && wr_sel<=ROWS && selected FIFO count < COLS. Writes are accepted in IDLE only, including after DONE so the next load can overlap result readout. Writes to an out-of-range wr_sel or a full FIFO are dropped.
- Schedule, RUN cycle t=0..: en[0]=1 for t<COLS, else 0; en[r] is en[r-1] registered.
- B FIFO pops when en[0]=1. b_pipe[0] = B FIFO head (combinational); b_pipe[r] is b_pipe[r-1] registered.
- Row r FIFO pops when en[r]=1. MAC r adds A_head[r]*b_pipe[r] to acc[r] when en[r]=1, otherwise holds.
- At the end of RUN, every FIFO is empty.
- Arithmetic: unsigned by default. Product is 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH with no saturation.
- A FIFO is never popped when empty; this is guaranteed by the ready gating and needs no extra check.

Optional Feature:
MATVEC_SIGNED_EN
- Defined: operands are two's complement; products are sign-extended to ACC_WIDTH before accumulating. c_out words are signed.
- Undefined: unsigned arithmetic as above.

Test Plan:
1. 8x8, all A=1, B=1; write all nine FIFOs; ready=1; pulse start -> busy for 15 cycles; done at start+16; every c_out word = 8; c_valid=1.
2. A=identity, B=1..8 -> c_out[r] = r+1; second run with B=8..1 without reset -> c_out[r] = 8-r.
3. All A=B=255 -> each word = 520200 (0x7F008); no wrap at ACC_WIDTH=24.
4. Load only 7 B entries, pulse start -> ignored, busy=0, ready=0. Write the 8th B entry, then a 9th -> 9th sees wr_ready=0 and is dropped. wr_sel=9 -> wr_ready=0.
5. Assert rst at RUN cycle 5 -> busy, c_valid and done go 0 immediately; no done pulse follows; ready=0; all FIFOs empty (wr_ready=1 for every sel).
6. With MATVEC_SIGNED_EN: A=0xFF (-1), B=0x02 -> each word = 0xFFFFF0 (-16); without the macro the same stimulus gives 0x000FF0.
